enigma_out_grouper: RTL and testbench

ENIGMA_OUT_GROUPER -- requirements
Module: enigma_out_grouper

---
 rtl/enigma_pkg.sv | 25 ++
 rtl/symb_fifo.sv | 87 ++++++++
 rtl/enigma_out_grouper.sv | 204 ++++++++++++++++++++
 tb/tb_enigma_out_grouper.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// ---------------------------------------------------------------------------
// enigma_pkg
// Definitions shared by the Enigma output path: the default alphabet size,
// the ASCII codes used when turning symbol codes into text, and the state
// encoding of the output grouping FSM.
// ---------------------------------------------------------------------------
package enigma_pkg;

    // Default alphabet size (A..Z)
    localparam int         LETTERS_DEF = 26;

    // ASCII code of the first letter; symbol code 0 maps to this character
    localparam logic [7:0] ASCII_A     = 8'h41;

    // ASCII space, inserted between letter groups
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Output FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // nothing presented, char_val_o low
        ST_LETTER = 2'd1,   // presenting a letter
        ST_SPACE  = 2'd2    // presenting the group separator
    } out_state_e;

endpackage

// File: rtl/symb_fifo.sv
// ---------------------------------------------------------------------------
// symb_fifo
// Single-clock synchronous FIFO used to buffer coded symbols between the
// cipher core and the output grouper.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset of pointers and count
//   clr_i      synchronous clear of pointers and count (wins over rd/wr)
//   wr_en_i    write request; taken when not full, or when full and a read
//              happens on the same edge
//   wr_data_i  write data
//   rd_en_i    read request (pop of the head); ignored when empty
//   rd_data_o  head of the FIFO (valid when empty_o is low)
//   full_o     FIFO holds DEPTH entries
//   empty_o    FIFO holds no entries
//   count_o    current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module symb_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_wr;
    logic             w_rd;

    assign full_o    = (r_count == DEPTH_C);
    assign empty_o   = (r_count == {(AW + 1){1'b0}});
    assign count_o   = r_count;
    assign rd_data_o = r_mem[r_rd_ptr];

    // A full FIFO can still take a write when the head leaves on the same edge
    assign w_wr = wr_en_i & (~full_o | rd_en_i);
    assign w_rd = rd_en_i & ~empty_o;

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else if (clr_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are never reset, only the pointers are
    always_ff @(posedge clk_i) begin
        if (w_wr && !clr_i) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/enigma_out_grouper.sv
// ---------------------------------------------------------------------------
// enigma_out_grouper
// Turns the coded-symbol stream of the cipher core into ASCII text split into
// groups of GROUP_LEN letters separated by single spaces. A space is only
// emitted once the letter that follows it is available, so the text never
// ends with a trailing space.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   flush_i     synchronous clear of buffer, group count and flags
//   symb_val_i  coded-symbol strobe
//   symbol_i    signed coded symbol; 0..LETTERS-1 are valid
//   char_o      ASCII character
//   char_val_o  char_o valid
//   char_rdy_i  sink ready; transfer when char_val_o && char_rdy_i
//   level_o     buffer occupancy
//   ovf_o       sticky: a valid symbol was dropped on a full buffer
//   bad_symb_o  one-cycle pulse after an out-of-range symbol
// ---------------------------------------------------------------------------
module enigma_out_grouper
    import enigma_pkg::*;
#(
    parameter int LETTERS    = LETTERS_DEF,
    parameter int GROUP_LEN  = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          symb_val_i,
    input  logic signed [6:0]             symbol_i,
    output logic [7:0]                    char_o,
    output logic                          char_val_o,
    input  logic                          char_rdy_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          ovf_o,
    output logic                          bad_symb_o
);

    localparam int              CW        = (LETTERS > 1) ? $clog2(LETTERS) : 1;
    localparam int              GW        = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
    localparam int              LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]      LETTERS_W = 8'(LETTERS);
    localparam logic [GW-1:0]   GRP_LAST  = GW'(GROUP_LEN - 1);

    out_state_e    r_state;
    logic [7:0]    r_char;
    logic          r_val;
    logic [GW-1:0] r_grp;
    logic          r_pend;
    logic          r_ovf;
    logic          r_bad;

    out_state_e    w_next_state;
    logic [7:0]    w_next_char;
    logic [GW-1:0] w_next_grp;
    logic          w_next_pend;
    logic          w_pop;
    logic          w_xfer;

    logic [7:0]    w_code_u;
    logic          w_in_range;
    logic          w_wr_req;
    logic          w_bad;
    logic          w_drop;
    logic [CW-1:0] w_head;
    logic [7:0]    w_letter;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_count;

    // A negative code has bit 6 set; zero-extending the rest gives the
    // magnitude to compare against the alphabet size
    assign w_code_u   = {1'b0, symbol_i};
    assign w_in_range = (symbol_i[6] == 1'b0) && (w_code_u < LETTERS_W);
    assign w_wr_req   = symb_val_i & w_in_range & ~flush_i;
    assign w_bad      = symb_val_i & ~w_in_range & ~flush_i;
    // Dropped only when full and the head is not leaving on this same edge
    assign w_drop     = w_wr_req & w_full & ~w_pop;
    assign w_xfer     = r_val & char_rdy_i;
    assign w_letter   = ASCII_A + 8'(w_head);

    symb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (flush_i),
        .wr_en_i   (w_wr_req),
        .wr_data_i (w_code_u[CW-1:0]),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_count)
    );

    // Output FSM next-state, next-character and group bookkeeping
    always_comb begin
        w_next_state = r_state;
        w_next_char  = r_char;
        w_next_grp   = r_grp;
        w_next_pend  = r_pend;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (r_pend) begin
                        // previous group closed while the buffer was empty
                        w_next_state = ST_SPACE;
                        w_next_char  = ASCII_SPACE;
                    end else begin
                        w_pop        = 1'b1;
                        w_next_state = ST_LETTER;
                        w_next_char  = w_letter;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LETTER: begin
                if (w_xfer) begin
                    if (r_grp == GRP_LAST) begin
                        w_next_grp = {GW{1'b0}};
                        if (!w_empty) begin
                            w_next_state = ST_SPACE;
                            w_next_char  = ASCII_SPACE;
                        end else begin
                            // defer the separator until another letter shows up
                            w_next_state = ST_IDLE;
                            w_next_pend  = 1'b1;
                        end
                    end else begin
                        w_next_grp = r_grp + GW'(1);
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_next_state = ST_LETTER;
                            w_next_char  = w_letter;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end
                end else begin
                    w_next_state = ST_LETTER;
                end
            end
            ST_SPACE: begin
                if (w_xfer) begin
                    w_next_pend = 1'b0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_LETTER;
                        w_next_char  = w_letter;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_SPACE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, output register and status flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_char  <= 8'h00;
            r_val   <= 1'b0;
            r_grp   <= {GW{1'b0}};
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bad   <= 1'b0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
            r_char  <= r_char;
            r_val   <= 1'b0;
            r_grp   <= {GW{1'b0}};
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_char  <= w_next_char;
            r_val   <= (w_next_state != ST_IDLE);
            r_grp   <= w_next_grp;
            r_pend  <= w_next_pend;
            r_ovf   <= r_ovf | w_drop;
            r_bad   <= w_bad;
        end
    end

    assign char_o     = r_char;
    assign char_val_o = r_val;
    assign level_o    = w_count;
    assign ovf_o      = r_ovf;
    assign bad_symb_o = r_bad;

endmodule

// File: tb/tb_enigma_out_grouper.sv
// ---------------------------------------------------------------------------
// tb_enigma_out_grouper
// Self-checking bench for enigma_out_grouper. The reference model is the
// expected text: every accepted letter is appended to a character queue,
// preceded by a space whenever it starts a new group of five (never for the
// first letter). Every handshake must deliver the queue head in order.
// ---------------------------------------------------------------------------
module tb_enigma_out_grouper;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              symb_val_i;
    logic signed [6:0] symbol_i;
    logic [7:0]        char_o;
    logic              char_val_o;
    logic              char_rdy_i;
    logic [4:0]        level_o;
    logic              ovf_o;
    logic              bad_symb_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         n_letters = 0;

    enigma_out_grouper #(
        .LETTERS    (26),
        .GROUP_LEN  (5),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .symb_val_i (symb_val_i),
        .symbol_i   (symbol_i),
        .char_o     (char_o),
        .char_val_o (char_val_o),
        .char_rdy_i (char_rdy_i),
        .level_o    (level_o),
        .ovf_o      (ovf_o),
        .bad_symb_o (bad_symb_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference text model
    function automatic void model_letter(input int code);
        if (n_letters > 0 && (n_letters % 5) == 0) exp_q.push_back(8'h20);
        exp_q.push_back(8'h41 + 8'(code));
        n_letters++;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        n_letters = 0;
    endfunction

    // One clock: sample before the edge, check after it, return on negedge
    task automatic tick();
        logic       pv, pr, pf, psv;
        logic [7:0] pc;
        int         ps;
        pv = char_val_o; pc = char_o; pr = char_rdy_i;
        pf = flush_i; psv = symb_val_i; ps = symbol_i;
        @(posedge clk);
        #1;
        if (!pf && pv && pr) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL xfer: got char %02h, required no character", pc);
            end else begin
                check("xfer_char", {24'd0, pc}, {24'd0, exp_q.pop_front()});
            end
        end
        if (!pf && pv && !pr) begin
            check("hold_val", {31'd0, char_val_o}, 32'd1);
            check("hold_char", {24'd0, char_o}, {24'd0, pc});
        end
        check("bad_pulse", {31'd0, bad_symb_o},
              {31'd0, (psv && !pf && (ps < 0 || ps >= 26))});
        @(negedge clk);
    endtask

    // Apply one cycle of input; acc says whether a valid code is expected to be kept
    task automatic drive(input bit v, input int s, input bit rdy, input bit acc);
        symb_val_i = v;
        symbol_i   = s[6:0];
        char_rdy_i = rdy;
        if (v && s >= 0 && s < 26 && acc) model_letter(s);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) drive(1'b0, 0, 1'b1, 1'b1);
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic do_flush();
        flush_i    = 1'b1;
        symb_val_i = 1'b1;
        symbol_i   = 7'sd3;
        char_rdy_i = 1'b0;
        model_clear();
        tick();
        flush_i    = 1'b0;
        symb_val_i = 1'b0;
    endtask

    typedef struct {
        bit         v;
        int         s;
        bit         rdy;
        bit         exp_val;
        logic [7:0] exp_char;
        int         exp_lvl;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // "HELLO W" cycle by cycle with the sink always ready
        tbl[0] = '{1'b1, 7,  1'b1, 1'b0, 8'h00, 1};
        tbl[1] = '{1'b1, 4,  1'b1, 1'b1, 8'h48, 1};
        tbl[2] = '{1'b1, 11, 1'b1, 1'b1, 8'h45, 1};
        tbl[3] = '{1'b1, 11, 1'b1, 1'b1, 8'h4C, 1};
        tbl[4] = '{1'b1, 14, 1'b1, 1'b1, 8'h4C, 1};
        tbl[5] = '{1'b1, 22, 1'b1, 1'b1, 8'h4F, 1};
        tbl[6] = '{1'b0, 0,  1'b1, 1'b1, 8'h20, 1};
        tbl[7] = '{1'b0, 0,  1'b1, 1'b1, 8'h57, 0};
        tbl[8] = '{1'b0, 0,  1'b1, 1'b0, 8'h00, 0};

        rst_i = 1'b1; flush_i = 1'b0; symb_val_i = 1'b0; symbol_i = 7'sd0; char_rdy_i = 1'b0;
        #1;
        check("rst_char",  {24'd0, char_o}, 32'd0);
        check("rst_val",   {31'd0, char_val_o}, 32'd0);
        check("rst_level", {27'd0, level_o}, 32'd0);
        check("rst_ovf",   {31'd0, ovf_o}, 32'd0);
        check("rst_bad",   {31'd0, bad_symb_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].rdy, 1'b1);
            check("tbl_val", {31'd0, char_val_o}, {31'd0, tbl[i].exp_val});
            if (tbl[i].exp_val) check("tbl_char", {24'd0, char_o}, {24'd0, tbl[i].exp_char});
            check("tbl_level", {27'd0, level_o}, tbl[i].exp_lvl);
        end
        check("hello_left", exp_q.size(), 32'd0);

        // Fresh group: ABCDE, long pause, no trailing space, then " Z"
        do_flush();
        for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 0, 1'b1, 1'b1);
        check("abcde_left", exp_q.size(), 32'd0);
        check("abcde_idle", {31'd0, char_val_o}, 32'd0);
        drive(1'b1, 25, 1'b1, 1'b1);
        drain();

        // Out-of-range codes are discarded with a one-cycle pulse
        drive(1'b1, -3, 1'b0, 1'b1);
        check("bad_neg", {31'd0, bad_symb_o}, 32'd1);
        check("bad_neg_lvl", {27'd0, level_o}, 32'd0);
        drive(1'b1, 26, 1'b0, 1'b1);
        check("bad_big", {31'd0, bad_symb_o}, 32'd1);
        drive(1'b0, 0, 1'b0, 1'b1);
        check("bad_gone", {31'd0, bad_symb_o}, 32'd0);
        check("bad_lvl", {27'd0, level_o}, 32'd0);
        check("bad_noout", {31'd0, char_val_o}, 32'd0);

        // Fill: one letter sits in the output register, 16 in the buffer
        do_flush();
        for (int i = 0; i < 17; i++) drive(1'b1, i, 1'b0, 1'b1);
        check("full_lvl", {27'd0, level_o}, 32'd16);
        check("full_ovf0", {31'd0, ovf_o}, 32'd0);
        check("full_char", {24'd0, char_o}, 32'h41);
        // Write while full but with a read on the same edge is kept
        drive(1'b1, 17, 1'b1, 1'b1);
        check("fullrd_lvl", {27'd0, level_o}, 32'd16);
        check("fullrd_ovf", {31'd0, ovf_o}, 32'd0);
        // Write while full without a read is dropped
        drive(1'b1, 18, 1'b0, 1'b0);
        check("ovf_set", {31'd0, ovf_o}, 32'd1);
        check("ovf_lvl", {27'd0, level_o}, 32'd16);
        drain();
        check("ovf_sticky", {31'd0, ovf_o}, 32'd1);

        // Stalled character stays put, then a flush clears everything
        drive(1'b1, 2, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 1'b0, 1'b1);
            check("stall_char", {24'd0, char_o}, 32'h43);
        end
        do_flush();
        check("flush_val", {31'd0, char_val_o}, 32'd0);
        check("flush_lvl", {27'd0, level_o}, 32'd0);
        check("flush_ovf", {31'd0, ovf_o}, 32'd0);

        // Asynchronous reset mid-handshake
        for (int i = 0; i < 3; i++) drive(1'b1, i + 10, 1'b0, 1'b1);
        symb_val_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_char",  {24'd0, char_o}, 32'd0);
        check("arst_val",   {31'd0, char_val_o}, 32'd0);
        check("arst_level", {27'd0, level_o}, 32'd0);
        check("arst_ovf",   {31'd0, ovf_o}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 7; i++) drive(1'b1, i, 1'b1, 1'b1);
        drain();

        // Randomized bursts; at most 16 letters outstanding so nothing overflows
        for (int r = 0; r < 40; r++) begin
            int nvalid;
            int sent;
            nvalid = int'($urandom_range(1, 16));
            sent   = 0;
            while (sent < nvalid) begin
                int  kind;
                int  s;
                bit  rdy;
                kind = int'($urandom_range(0, 9));
                rdy  = 1'($urandom_range(0, 1));
                if (kind < 6) begin
                    s = int'($urandom_range(0, 25));
                    drive(1'b1, s, rdy, 1'b1);
                    sent++;
                end else if (kind < 8) begin
                    if ($urandom_range(0, 1) == 0) s = -int'($urandom_range(1, 64));
                    else s = int'($urandom_range(26, 63));
                    drive(1'b1, s, rdy, 1'b1);
                end else begin
                    drive(1'b0, 0, rdy, 1'b1);
                end
            end
            drain();
        end
        check("rand_ovf", {31'd0, ovf_o}, 32'd0);
        check("rand_lvl", {27'd0, level_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
